// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter and the keyed mux chain it drives.
// State encodings and the default key codes live here so both sides agree.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OWN     = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_e;

   // A key that no mux stage decodes; the chain passes nothing through.
   localparam logic [7:0] ARB_IDLE_KEY = 8'h00;
   localparam logic [7:0] ARB_KEY_BASE = 8'h01;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant/key bundle between the requesters and the arbiter.
// The slave modport is the arbiter side.
interface bus_arbiter_if #(
   parameter int NUM_REQ  = 4,
   parameter int KEY_SIZE = 8
);
   logic [NUM_REQ-1:0]  req;
   logic [NUM_REQ-1:0]  lock;
   logic [NUM_REQ-1:0]  grant;
   logic [KEY_SIZE-1:0] key;
   logic                bus_busy;

   modport master (
      output req,
      output lock,
      input  grant,
      input  key,
      input  bus_busy
   );

   modport slave (
      input  req,
      input  lock,
      output grant,
      output key,
      output bus_busy
   );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin winner search: first set req bit above last_ptr, wrapping.
// Purely combinational; the previous owner naturally lands last in line.
module bus_arbiter_rr_pick #(
   parameter int NUM_REQ = 4,
   localparam int PTR_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   last_ptr,
   output logic [PTR_W-1:0]   winner,
   output logic               valid
);

   int idx;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = int'(last_ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!valid && req[PTR_W'(idx)]) begin
            winner = PTR_W'(idx);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter driving the key of a keyed pass-through mux chain,
// with a forced one-cycle idle key between successive owners.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | no owner, key idle; arbitrate every cycle
//   ST_OWN     | one requester granted; watch its req, lock, hold count
//   ST_RELEASE | single idle-key gap after an owner; arbitrate again
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int                  NUM_REQ  = 4,
   parameter int                  KEY_SIZE = 8,
   parameter logic [KEY_SIZE-1:0] KEY_BASE = ARB_KEY_BASE,
   parameter logic [KEY_SIZE-1:0] IDLE_KEY = ARB_IDLE_KEY,
   parameter int                  MAX_HOLD = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   bus_arbiter_if.slave bus
);

   localparam int PTR_W  = $clog2(NUM_REQ);
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

   arb_state_e          state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [KEY_SIZE-1:0] key_q, key_d;
   logic                busy_q, busy_d;
   logic [PTR_W-1:0]    last_ptr_q, last_ptr_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

   logic [PTR_W-1:0]    pick_idx;
   logic                pick_valid;

   bus_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req      (bus.req),
      .last_ptr (last_ptr_q),
      .winner   (pick_idx),
      .valid    (pick_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         key_q      <= IDLE_KEY;
         busy_q     <= 1'b0;
         last_ptr_q <= PTR_W'(NUM_REQ - 1);
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         key_q      <= key_d;
         busy_q     <= busy_d;
         last_ptr_q <= last_ptr_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   // last_ptr doubles as the owner index while in ST_OWN.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      key_d      = key_q;
      busy_d     = busy_q;
      last_ptr_d = last_ptr_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_OWN: begin
            if (!bus.req[last_ptr_q] ||
                (hold_cnt_q == HOLD_MAX && !bus.lock[last_ptr_q])) begin
               state_d    = ST_RELEASE;
               grant_d    = '0;
               key_d      = IDLE_KEY;
               busy_d     = 1'b0;
               hold_cnt_d = '0;
            end else if (hold_cnt_q != HOLD_MAX) begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         ST_IDLE, ST_RELEASE: begin
            if (pick_valid) begin
               state_d    = ST_OWN;
               grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
               key_d      = KEY_BASE + KEY_SIZE'(pick_idx);
               busy_d     = 1'b1;
               last_ptr_d = pick_idx;
               hold_cnt_d = HOLD_W'(1);
            end else begin
               state_d    = ST_IDLE;
               grant_d    = '0;
               key_d      = IDLE_KEY;
               busy_d     = 1'b0;
               hold_cnt_d = '0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            key_d      = IDLE_KEY;
            busy_d     = 1'b0;
            hold_cnt_d = '0;
         end
      endcase
   end

   assign bus.grant    = grant_q;
   assign bus.key      = key_q;
   assign bus.bus_busy = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random req/lock traffic,
// compared cycle by cycle against an owner/hold-count reference model.
module tb_bus_arbiter;

   localparam int N        = 4;
   localparam int MAX_HOLD = 16;
   localparam int KBASE    = 1;
   localparam int KIDLE    = 0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   bus_arbiter_if #(.NUM_REQ(N), .KEY_SIZE(8)) bus ();

   bus_arbiter #(
      .NUM_REQ  (N),
      .KEY_SIZE (8),
      .KEY_BASE (8'h01),
      .IDLE_KEY (8'h00),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model: who owns the bus next cycle and for how long so far
   int m_owner;
   int m_held;
   int m_last;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic int grant_index(input logic [N-1:0] g);
      for (int i = 0; i < N; i++) if (g[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_last  = N - 1;
   endtask

   // An owner stays while requesting unless it has used its quota unlocked;
   // otherwise the cycle after any ownership (or idle) is an arbitration.
   task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l);
      int w;
      if (m_owner >= 0) begin
         if (!r[m_owner] || (m_held >= MAX_HOLD && !l[m_owner])) m_owner = -1;
         else if (m_held < MAX_HOLD) m_held++;
      end else begin
         w = pick(r, m_last);
         if (w >= 0) begin
            m_owner = w;
            m_held  = 1;
            m_last  = w;
         end
      end
   endtask

   task automatic check_outputs();
      logic [31:0] exp_g, exp_k, exp_b, key_of_g;
      int gi;
      exp_g = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      exp_k = (m_owner >= 0) ? 32'(KBASE + m_owner) : 32'(KIDLE);
      exp_b = (m_owner >= 0) ? 32'd1 : 32'd0;
      chk("grant", 32'(bus.grant), exp_g);
      chk("key", 32'(bus.key), exp_k);
      chk("busy", 32'(bus.bus_busy), exp_b);
      chk("onehot", 32'($onehot0(bus.grant)), 32'd1);
      gi = grant_index(bus.grant);
      key_of_g = (gi >= 0) ? 32'(KBASE + gi) : 32'(KIDLE);
      chk("key_vs_grant", 32'(bus.key), key_of_g);
   endtask

   task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l);
      bus.req  = r;
      bus.lock = l;
      @(posedge clk);
      model_step(r, l);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      bus.req  = '0;
      bus.lock = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst_n = 1'b1;
   endtask

   logic [N-1:0] r, l, prev_g;
   int owners[$];
   int keys[$];
   int run_len, lock_cnt;
   int exp_owner[5] = '{0, 1, 2, 3, 0};

   initial begin
      bus.req  = '0;
      bus.lock = '0;

      // idle after reset, then async reset while owning
      do_reset();
      repeat (5) cycle(4'b0000, 4'b0000);
      repeat (3) cycle(4'b0001, 4'b0000);
      chk("pre_rst_grant", 32'(bus.grant), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_grant", 32'(bus.grant), 32'h0);
      chk("rst_key", 32'(bus.key), 32'h0);
      chk("rst_busy", 32'(bus.bus_busy), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // all requesting, each owner drops after two owned cycles
      do_reset();
      r = 4'b1111;
      prev_g = '0;
      for (int c = 0; c < 40 && owners.size() < 5; c++) begin
         cycle(r, 4'b0000);
         if (bus.grant != 0 && prev_g == 0) begin
            owners.push_back(grant_index(bus.grant));
            keys.push_back(int'(bus.key));
         end
         prev_g = bus.grant;
         r = 4'b1111;
         if (m_owner >= 0 && m_held == 2) r[m_owner] = 1'b0;
      end
      chk("rr_count", 32'(owners.size()), 32'd5);
      for (int i = 0; i < owners.size() && i < 5; i++) begin
         chk("rr_owner", 32'(owners[i]), 32'(exp_owner[i]));
         chk("rr_key", 32'(keys[i]), 32'(KBASE + exp_owner[i]));
      end

      // sole unlocked requester is preempted every MAX_HOLD cycles
      do_reset();
      run_len = 0;
      for (int c = 0; c < 40; c++) begin
         cycle(4'b0100, 4'b0000);
         if (bus.grant == 4'b0100) run_len++;
         else if (run_len != 0) begin
            chk("hold_len", 32'(run_len), 32'(MAX_HOLD));
            chk("gap_key", 32'(bus.key), 32'h0);
            run_len = 0;
         end
      end

      // locked owner holds past MAX_HOLD, releases when lock drops
      do_reset();
      lock_cnt = 0;
      for (int c = 0; c < 30; c++) begin
         cycle(4'b0011, 4'b0001);
         if (bus.grant == 4'b0001) lock_cnt++;
      end
      chk("lock_hold", 32'(lock_cnt), 32'd30);
      cycle(4'b0011, 4'b0000);
      chk("unlock_rel", 32'(bus.grant), 32'h0);
      cycle(4'b0011, 4'b0000);
      chk("unlock_next", 32'(bus.grant), 32'b0010);
      chk("unlock_key", 32'(bus.key), 32'h02);

      // a new request never interrupts the owner
      do_reset();
      repeat (3) cycle(4'b0100, 4'b0000);
      repeat (3) cycle(4'b0110, 4'b0000);
      chk("no_preempt", 32'(bus.grant), 32'b0100);
      cycle(4'b0010, 4'b0000);
      chk("handoff_gap", 32'(bus.grant), 32'h0);
      cycle(4'b0010, 4'b0000);
      chk("handoff_grant", 32'(bus.grant), 32'b0010);
      chk("handoff_key", 32'(bus.key), 32'h02);

      // random traffic with sticky requests and sparse locks
      do_reset();
      r = 4'(($urandom % 16));
      l = '0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) l = 4'($urandom_range(0, 15));
         else if ($urandom_range(0, 3) == 0) l = '0;
         cycle(r, l);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
